// File: rtl/vid_mixer_pkg.sv
// Shared types for the video mixer pixel path: pixel format, line FIFO word
// layout, frame geometry and the scanline reader frame-sync states.
package vid_mixer_pkg;

  localparam int H_RES     = 320;
  localparam int V_RES     = 240;
  localparam int FRAME_PIX = H_RES * V_RES;

  typedef logic [14:0] pixel_t;

  typedef struct packed {
    logic   start;
    pixel_t pixel;
  } fifo_word_t;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } rd_state_e;

endpackage

// File: rtl/scanline_fifo.sv
// Single-clock show-ahead FIFO with a registered RAM read: a word written into
// an empty FIFO reaches the head one cycle after the write edge.
module scanline_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [FW-1:0]    fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr;
  logic [FW-1:0]    fill_q, avail;
  logic             valid_q, do_push, do_pop;

  assign full    = (fill_q == FW'(DEPTH));
  assign empty   = !valid_q;
  assign fill    = fill_q;
  assign do_push = push && !full;
  assign do_pop  = pop && valid_q;

  // Words already committed to RAM before this edge, after the pop; only
  // these are safe to read, so a same-edge write never leaks to the head.
  assign avail   = fill_q - FW'(do_pop);
  assign rd_addr = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      rdata   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fill_q  <= fill_q + FW'(do_push) - FW'(do_pop);
      valid_q <= (avail != '0);
      // Head register holds its last value while the FIFO runs dry.
      if (avail != '0) rdata <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/scanline_reader.sv
// Frame-buffer pixel receiver: hunts for start-of-frame, checks frame length,
// buffers pixels in a show-ahead line FIFO. Optional SCANLINE_READER_STATS_EN
// adds saturating frame and sync-error counters.
module scanline_reader import vid_mixer_pkg::*; #(
  parameter int DEPTH     = 512,
  parameter int FRAME_PIX = vid_mixer_pkg::FRAME_PIX,
  parameter int PIX_W     = 15
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iFB_START,
  input  logic [PIX_W-1:0] iFB_DATA,
  input  logic             iFB_DATAVALID,
  output logic             oFB_READY,
  output logic [PIX_W-1:0] oPIX_DATA,
  output logic             oPIX_VALID,
  output logic             oPIX_START,
  input  logic             iPIX_READ,
  output logic             oPIX_EMPTY,
  output logic             oSYNC_ERR
`ifdef SCANLINE_READER_STATS_EN
  ,
  output logic [15:0]      oFRAME_CNT,
  output logic [15:0]      oERR_CNT
`endif
);

  localparam int CNT_W = $clog2(FRAME_PIX + 1);
  localparam int FW    = $clog2(DEPTH + 1);

  rd_state_e        state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             err_nxt, wr_en, accept, at_end, rdy_en_q;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_fill;
  logic [PIX_W:0]   head_word;

  // Ready stays low through reset and rises on the first edge after release.
  assign oFB_READY = rdy_en_q && (fifo_fill != FW'(DEPTH)) && !fifo_full;
  assign accept    = iFB_DATAVALID && oFB_READY;
  assign at_end    = (cnt_q == CNT_W'(FRAME_PIX));

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    wr_en     = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      case (state_q)
        HUNT: begin
          if (iFB_START) begin
            wr_en     = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (iFB_START) begin
            // Start beat mid-frame is a short frame, but still begins a new one.
            wr_en   = 1'b1;
            cnt_nxt = CNT_W'(1);
            err_nxt = !at_end;
          end else if (at_end) begin
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = cnt_q + 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      oSYNC_ERR <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      oSYNC_ERR <= err_nxt;
      rdy_en_q  <= 1'b1;
    end
  end

  scanline_fifo #(
    .WIDTH (PIX_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRESET),
    .push  (wr_en),
    .wdata ({iFB_START, iFB_DATA}),
    .pop   (iPIX_READ),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fifo_fill)
  );

  assign oPIX_VALID = !fifo_empty;
  assign oPIX_EMPTY = fifo_empty;
  assign oPIX_DATA  = head_word[PIX_W-1:0];
  assign oPIX_START = head_word[PIX_W] && !fifo_empty;

`ifdef SCANLINE_READER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oFRAME_CNT <= '0;
      oERR_CNT   <= '0;
    end else begin
      if (wr_en && iFB_START) oFRAME_CNT <= sat_inc(oFRAME_CNT);
      if (oSYNC_ERR)          oERR_CNT   <= sat_inc(oERR_CNT);
    end
  end
`endif

endmodule
